multiplier: RTL and testbench



---
 rtl/multiplier.sv | 90 +++++++++
 tb/tb_multiplier.sv | 118 +++++++++++
 2 files changed

// File: rtl/multiplier.sv
// Signed WIDTH x WIDTH multiplier: radix-4 Booth partial products, carry-save
// reduction, final carry-propagate add; combinational product plus registered copy.
module multiplier #(
  parameter int unsigned WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0]   result_q
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NDIG  = (WIDTH + 1) / 2;
  localparam int unsigned BEW   = 2 * NDIG + 1;
  // One row per Booth digit plus one row gathering all negation carry-ins.
  localparam int unsigned NROWS = NDIG + 1;

  logic [BEW-1:0]   be;
  logic [PW-1:0]    rows [NROWS];
  logic [NDIG-1:0]  neg;
  logic [PW-1:0]    cs_sum;
  logic [PW-1:0]    cs_carry;

  // B with an implicit zero below the LSB, sign-extended to an even digit count.
  always_comb begin
    be = '0;
    for (int k = 1; k < int'(BEW); k++) begin
      be[k] = (k <= int'(WIDTH)) ? B[k-1] : B[WIDTH-1];
    end
  end

  // Booth-select each digit's magnitude (0, A or 2A), one's complement when negative,
  // full sign extension, then place at weight 4^i.
  always_comb begin
    logic [2:0]     grp;
    logic           one;
    logic           two;
    logic [WIDTH:0] mag;
    logic [PW-1:0]  ext;
    neg = '0;
    rows[NROWS-1] = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      grp    = be[2*i +: 3];
      one    = grp[1] ^ grp[0];
      two    = (grp[2] & ~grp[1] & ~grp[0]) | (~grp[2] & grp[1] & grp[0]);
      neg[i] = grp[2] & ~(grp[1] & grp[0]);
      if (one) begin
        mag = {A[WIDTH-1], A};
      end else if (two) begin
        mag = {A, 1'b0};
      end else begin
        mag = '0;
      end
      if (neg[i]) begin
        mag = ~mag;
      end
      ext     = {{(PW-WIDTH-1){mag[WIDTH]}}, mag};
      rows[i] = ext << (2 * i);
      rows[NROWS-1][2*i] = neg[i];
    end
  end

  // Linear chain of 3:2 compressors keeps sum and carry vectors separate until the end.
  always_comb begin
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] r;
    s = rows[0];
    c = rows[1];
    for (int k = 2; k < int'(NROWS); k++) begin
      r = rows[k];
      {s, c} = {s ^ c ^ r, ((s & c) | (s & r) | (c & r)) << 1};
    end
    cs_sum   = s;
    cs_carry = c;
  end

  assign result = cs_sum + cs_carry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else begin
      result_q <= result;
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier (WIDTH = 17): directed literal cases, reset
// behaviour, and a randomized run against a plain-arithmetic signed product model.
module tb_multiplier;

  localparam int unsigned W  = 17;
  localparam int unsigned PW = 2 * W;

  logic          clk;
  logic          reset;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [PW-1:0] result;
  logic [PW-1:0] result_q;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [PW-1:0] exp_q = '0;

  multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .result   (result),
    .result_q (result_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[PW-1:0];
  endfunction

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (A=%h B=%h t=%0t)", name, got, want, A, B, $time);
    end
  endtask

  // Expected registered product: cleared while reset is low, else last captured product.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_q = '0;
    else        exp_q = prod(A, B);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_result", result, prod(A, B));
      check("model_result_q", result_q, exp_q);
    end
  end

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PW-1:0] want, input string name);
    @(posedge clk); #1;
    A = a; B = b;
    @(negedge clk);
    check(name, result, want);
    @(posedge clk); #1;
    check({name, "_q"}, result_q, want);
  endtask

  initial begin
    reset = 1'b0;
    A = 17'd3;
    B = 17'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", result, 34'd15);
    check("reset_result_q", result_q, 34'd0);
    chk_en = 1'b1;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("release_q", result_q, 34'd15);

    apply(17'd3,     17'd5,     34'd15,           "small_pos");
    apply(17'h1FFFF, 17'h1FFFF, 34'd1,            "neg1_neg1");
    apply(17'h1FFFD, 17'd7,     34'h3FFFFFFEB,    "neg3_7");
    apply(17'h10000, 17'h10000, 34'h100000000,    "min_min");
    apply(17'h0FFFF, 17'h0FFFF, 34'h0FFFE0001,    "max_max");
    apply(17'h10000, 17'h0FFFF, 34'h300010000,    "min_max");
    apply(17'd0,     17'h1ABCD, 34'd0,            "zero_a");
    apply(17'h0ABCD, 17'd0,     34'd0,            "zero_b");
    apply(17'h0FFFF, 17'h10000, 34'h300010000,    "max_min");

    // Asynchronous clear between edges.
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async_clear_q", result_q, 34'd0);
    check("async_clear_result", result, 34'h300010000);
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rerelease_q", result_q, 34'h300010000);

    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      A = W'($urandom);
      B = W'($urandom);
      if ($urandom_range(0, 31) == 0) A = '0;
      if ($urandom_range(0, 31) == 0) B = W'(17'h10000);
    end
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
